sync_fifo_flex: RTL and testbench
=================================

// Module: sync_fifo_flex
// PURPOSE
// - Single-clock FIFO; parametrised successor to the dual-clock FIFO used on the adapter datapath.
// - Supports arbitrary (non-power-of-two) DEPTH, occupancy count, almost-full/almost-empty flags, synchronous flush.
// - Uses valid/ready handshakes on both sides with first-word-fall-through (FWFT) read.
// - Buffers sideband/flit staging inside one clock domain, where pointer synchronisation is unnecessary.
// PARAMETERS
// - DEPTH     16  number of entries; any value >= 2 (power of two not required)
// - WIDTH     8   data width in bits
// - AF_LEVEL  14  almost_full asserted when count >= AF_LEVEL; legal range 1..DEPTH
// - AE_LEVEL  2   almost_empty asserted when count <= AE_LEVEL; legal range 0..DEPTH-1
// - CW = $clog2(DEPTH+1) (localparam): count width
// PORTS
// - clk           in   1      single clock; all state changes on posedge
// - rst           in   1      asynchronous, active-high reset
// - flush         in   1      synchronous clear of contents
// - valid_w       in   1      write request
// - ready_w       out  1      FIFO can accept a write this cycle
// - data_w        in   WIDTH  write data
// - valid_r       out  1      read data available
// - ready_r       in   1      consumer accepts data_r
// - data_r        out  WIDTH  head-of-queue data (FWFT)
// - count         out  CW     current occupancy, 0..DEPTH
// - almost_full   out  1      count >= AF_LEVEL
// - almost_empty  out  1      count <= AE_LEVEL
// BEHAVIOUR
// - Reset (rst=1, async): wptr=rptr=0, count=0; ready_w=0 while rst high, 1 after release; valid_r=0.
// - Reset values (cont.): data_r=0, almost_full=0, almost_empty=1. Storage array is not reset.
// - Handshakes:
//   - Write accepted iff valid_w & ready_w. ready_w = ~rst & ~flush & (count != DEPTH).
//   - Read accepted iff valid_r & ready_r. valid_r = ~flush & (count != 0).
//   - ready_w never depends on ready_r: no write while full, even with a simultaneous read.
// - data_r = mem[rptr] when valid_r, else 0. Combinational from registered state; no read latency.
// - Write-to-read latency: 1 cycle (accepted at edge N, valid_r high after edge N).
// - Pointers: on accept, ptr <= (ptr == DEPTH-1) ? 0 : ptr+1. Explicit wrap; no modulo-2^n aliasing.
// - count:
//   - +1 on write only; -1 on read only; unchanged on simultaneous write+read.
//   - Never exceeds DEPTH or underflows 0 (guaranteed by the handshake).
// - Flags: almost_full/almost_empty are combinational compares on registered count; no extra latency.
// - flush=1 at an edge: wptr=rptr=count=0 next cycle. During the flush cycle, ready_w=0 and valid_r=0.
//   Neither side's transfer completes; flush dominates all traffic.
// - rst asserted mid-operation: immediate return to reset values; queued data is lost.
// - FSM-free. The state is {wptr, rptr, count}; full/empty are derived only from count.
// CONFIGURATION
// - Macro SYNC_FIFO_FLEX_BYPASS_EN:
//   - Defined: when count==0 & ~flush & valid_w, valid_r=1 and data_r=data_w combinationally.
//     - If ready_r is also high: the word passes through without being stored; count stays 0.
//     - If ready_r is low: the word is stored normally.
//   - Undefined: no comb path from data_w/valid_w to data_r/valid_r; write-to-read latency is always 1 cycle.
// TESTING
// - DEPTH=5: write 0x11..0x15 with ready_r=0 -> count 5, ready_w=0 after the 5th write; 6th valid_w not accepted.
// - DEPTH=5: 12 writes interleaved with reads -> data_r order 0x01..0x0C exact; pointer wrap at 4->0 is lossless.
// - count=2, valid_w=ready_r=1 for 3 cycles -> count stays 2, output order preserved.
// - AF_LEVEL=4, AE_LEVEL=1: fill 0->5 -> almost_empty high at count 0..1, almost_full high at count 4..5.
// - count=3, flush pulse with valid_w=ready_r=1 -> no transfer that cycle; next cycle count=0, valid_r=0.
// - rst pulse mid-stream (count=3) -> count=0, valid_r=0, data_r=0 immediately.
// - rst pulse mid-stream: with BYPASS_EN, empty FIFO, valid_w=ready_r=1, data_w=0xA5 -> same-cycle data_r=0xA5, count stays 0.

Source files
------------

// File: rtl/sync_fifo_flex.sv
// Single-clock FWFT FIFO with arbitrary DEPTH, occupancy count, almost flags and synchronous flush.
// Optional SYNC_FIFO_FLEX_BYPASS_EN: an empty FIFO presents the incoming word combinationally.
module sync_fifo_flex #(
   parameter int DEPTH    = 16,
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             valid_w,
   output logic             ready_w,
   input  logic [WIDTH-1:0] data_w,
   output logic             valid_r,
   input  logic             ready_r,
   output logic [WIDTH-1:0] data_r,
   output logic [CW-1:0]    count,
   output logic             almost_full,
   output logic             almost_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             empty;
   logic             full;
   logic             bypass;
   logic             pass_thru;
   logic             do_wr;
   logic             do_rd;

   // Explicit wrap so non-power-of-two depths never alias.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign empty = (count == '0);
   assign full  = (count == DEPTH_C);

   // A side transfers on a clock edge only when its valid and ready are both high;
   // ready_w ignores ready_r, and flush drops both handshakes for that cycle.
   assign ready_w = ~rst & ~flush & ~full;

`ifdef SYNC_FIFO_FLEX_BYPASS_EN
   assign bypass  = ~rst & ~flush & empty & valid_w;
   assign valid_r = (~flush & ~empty) | bypass;
   assign data_r  = (~flush & ~empty) ? mem[rptr] :
                    bypass            ? data_w    : '0;
`else
   assign bypass  = 1'b0;
   assign valid_r = ~flush & ~empty;
   assign data_r  = valid_r ? mem[rptr] : '0;
`endif

   // A bypassed word consumed in the same cycle is never stored.
   assign pass_thru = bypass & ready_r;
   assign do_wr     = valid_w & ready_w & ~pass_thru;
   assign do_rd     = valid_r & ready_r & ~pass_thru;

   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_wr) wptr <= ptr_inc(wptr);
         if (do_rd) rptr <= ptr_inc(rptr);
         case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= data_w;
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Randomised bench for sync_fifo_flex (DEPTH=5, AF=4, AE=1) against a queue-based reference model.
module tb_sync_fifo_flex;

   localparam int DEPTH = 5;
   localparam int W     = 8;
   localparam int AF    = 4;
   localparam int AE    = 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          valid_w = 1'b0;
   logic          ready_w;
   logic [W-1:0]  data_w = '0;
   logic          valid_r;
   logic          ready_r = 1'b0;
   logic [W-1:0]  data_r;
   logic [CW-1:0] count;
   logic          almost_full;
   logic          almost_empty;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  got_q[$];
   int            total = 0;
   int            bad = 0;

   sync_fifo_flex #(.DEPTH(DEPTH), .WIDTH(W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .valid_w(valid_w), .ready_w(ready_w), .data_w(data_w),
      .valid_r(valid_r), .ready_r(ready_r), .data_r(data_r),
      .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic vw, input logic [W-1:0] d, input logic rr);
      @(posedge clk);
      #2;
      rst = r; flush = f; valid_w = vw; data_w = d; ready_r = rr;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   // Reference model: the FIFO contents as a queue, updated with the transfer rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
      end else if (flush) begin
         exp_q.delete();
      end else begin
         int n;
         logic wr, rd, pass;
         n = exp_q.size();
`ifdef SYNC_FIFO_FLEX_BYPASS_EN
         pass = (n == 0) && valid_w && ready_r;
`else
         pass = 1'b0;
`endif
         wr = valid_w && (n != DEPTH) && !pass;
         rd = ready_r && (n != 0) && !pass;
         if (rd) void'(exp_q.pop_front());
         if (wr) exp_q.push_back(data_w);
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      int n;
      logic e_vr;
      logic [W-1:0] e_dr;
      n = exp_q.size();
      e_vr = !flush && (n != 0);
      e_dr = (e_vr && n != 0) ? exp_q[0] : '0;
`ifdef SYNC_FIFO_FLEX_BYPASS_EN
      if (!rst && !flush && n == 0 && valid_w) begin
         e_vr = 1'b1;
         e_dr = data_w;
      end
`endif
      chk("ready_w", 32'(ready_w), 32'(!rst && !flush && n != DEPTH));
      chk("valid_r", 32'(valid_r), 32'(e_vr));
      chk("data_r", 32'(data_r), 32'(e_dr));
      chk("count", 32'(count), 32'(n));
      chk("almost_full", 32'(almost_full), 32'(n >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
      if (valid_r && ready_r && !rst) got_q.push_back(data_r);
   end

   initial begin
      int w;
      // Reset state
      @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ready_w", 32'(ready_w), 32'd0);
      chk("rst_valid_r", 32'(valid_r), 32'd0);
      chk("rst_ae", 32'(almost_empty), 32'd1);
      chk("rst_af", 32'(almost_full), 32'd0);
      idle(1);

      // Fill 0x11..0x15, then a rejected sixth write
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, W'(8'h11 + i), 1'b0);
      idle(1);
      @(negedge clk);
      chk("full_count", 32'(count), 32'd5);
      chk("full_ready_w", 32'(ready_w), 32'd0);
      chk("full_head", 32'(data_r), 32'h11);
      got_q.delete();
      for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
      idle(1);
      chk("drain_n", 32'(got_q.size()), 32'd5);
      for (int i = 0; i < 5 && i < got_q.size(); i++) chk("drain_order", 32'(got_q[i]), 32'h11 + 32'(i));

      // 12 writes interleaved with random reads; pointer wraps twice
      got_q.delete();
      w = 1;
      for (int i = 0; i < 300 && got_q.size() < 12; i++) begin
         logic vw;
         vw = (w <= 12) && ($urandom_range(0, 3) != 0);
         drive(1'b0, 1'b0, vw, W'(w), 1'($urandom_range(0, 1)));
         @(negedge clk);
         if (vw && ready_w) w++;
      end
      idle(1);
      chk("wrap_n", 32'(got_q.size()), 32'd12);
      for (int i = 0; i < 12 && i < got_q.size(); i++) chk("wrap_order", 32'(got_q[i]), 32'(i + 1));

      // Almost flags while filling 0 -> 5
      drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         drive(1'b0, 1'b0, 1'b1, W'(8'h40 + k), 1'b0);
         idle(1);
         @(negedge clk);
         chk("flag_count", 32'(count), 32'(k));
         chk("flag_af", 32'(almost_full), 32'(k >= 4));
         chk("flag_ae", 32'(almost_empty), 32'(k <= 1));
      end

      // Count 2 held under simultaneous write+read
      drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
      got_q.delete();
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, W'(8'hB0 + i), 1'b1);
      idle(1);
      @(negedge clk);
      chk("simul_count", 32'(count), 32'd2);
      chk("simul_head", 32'(data_r), 32'hB1);
      chk("simul_order0", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'hA1);

      // Flush with count 3 and both sides active
      drive(1'b0, 1'b0, 1'b1, 8'hB3, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 8'hCC, 1'b1);
      @(negedge clk);
      chk("flush_ready_w", 32'(ready_w), 32'd0);
      chk("flush_valid_r", 32'(valid_r), 32'd0);
      idle(1);
      @(negedge clk);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_after_vr", 32'(valid_r), 32'd0);

      // Async reset mid-stream at count 3
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, W'(8'hD0 + i), 1'b0);
      idle(1);
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("mrst_count", 32'(count), 32'd0);
      chk("mrst_valid_r", 32'(valid_r), 32'd0);
      chk("mrst_data_r", 32'(data_r), 32'd0);
      idle(1);

`ifdef SYNC_FIFO_FLEX_BYPASS_EN
      drive(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
      @(negedge clk);
      chk("byp_data_r", 32'(data_r), 32'hA5);
      chk("byp_valid_r", 32'(valid_r), 32'd1);
      idle(1);
      @(negedge clk);
      chk("byp_count", 32'(count), 32'd0);
`endif

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 600; i++) begin
         int mode;
         mode = (i / 100) % 3;
         drive(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 24) == 0),
               1'($urandom_range(0, 3) < (mode == 1 ? 3 : 2)), W'($urandom),
               1'($urandom_range(0, 3) < (mode == 2 ? 3 : 1)));
      end
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
